// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg : shared constants and types for the 7-segment scan controller
// Rev 1.0
// ============================================================================
package seg7_pkg;

   localparam int DIGIT_COUNT      = 4;
   localparam int SLOT_W           = 2;
   localparam int DEFAULT_PRESCALE = 100000;

   typedef logic [SLOT_W-1:0] slot_idx_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_refresh_prescaler.sv
`default_nettype none
// ============================================================================
// seg7_refresh_prescaler : free-running divider, one-cycle TICK every PRESCALE
// Rev 1.0
// ============================================================================
module seg7_refresh_prescaler
   import seg7_pkg::*;
#(
   parameter int PRESCALE = DEFAULT_PRESCALE,
   parameter int CNT_W    = 17
) (
   input  logic CLK,
   input  logic RESET,
   output logic TICK
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] r_count;
   logic             w_last;

   assign w_last = (r_count == C_LAST);
   assign TICK   = w_last;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_count <= '0;
      end else if (w_last) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule : seg7_refresh_prescaler
`default_nettype wire

// File: rtl/seg7_scan_controller.sv
`default_nettype none
// ============================================================================
// seg7_scan_controller : 4-digit multiplexed display scan with frame-aligned
// double-buffered load (req/ack). Rev 1.0
// ============================================================================
module seg7_scan_controller
   import seg7_pkg::*;
#(
   parameter int PRESCALE = DEFAULT_PRESCALE,
   parameter int CNT_W    = 17
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       LOAD_REQ_IN,
   input  logic [4*DIGIT_COUNT-1:0]   DIGITS_IN,
   input  logic [DIGIT_COUNT-1:0]     DOTS_IN,
   output logic                       LOAD_ACK_OUT,
   output logic                       FRAME_DONE_OUT,
   output logic [SLOT_W-1:0]          SEG_SELECT_OUT,
   output logic [3:0]                 BIN_OUT,
   output logic                       DOT_OUT
);

   localparam slot_idx_t C_LAST_SLOT = slot_idx_t'(DIGIT_COUNT - 1);

   logic                     w_tick;
   logic                     w_boundary;
   slot_idx_t                r_index;
   logic [4*DIGIT_COUNT-1:0] r_digits;
   logic [DIGIT_COUNT-1:0]   r_dots;
   logic                     r_ack;
   logic                     r_frame_done;

   seg7_refresh_prescaler #(
      .PRESCALE (PRESCALE),
      .CNT_W    (CNT_W)
   ) u_prescaler (
      .CLK   (CLK),
      .RESET (RESET),
      .TICK  (w_tick)
   );

   assign w_boundary = w_tick && (r_index == C_LAST_SLOT);

   // The index wraps 3->0 naturally on the boundary tick, so a capture on
   // that edge always starts the new frame at slot 0.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_index      <= '0;
         r_digits     <= '0;
         r_dots       <= '0;
         r_ack        <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_ack        <= 1'b0;
         r_frame_done <= w_boundary;
         if (w_tick) begin
            r_index <= r_index + slot_idx_t'(1);
         end
         if (w_boundary && LOAD_REQ_IN) begin
            r_digits <= DIGITS_IN;
            r_dots   <= DOTS_IN;
            r_ack    <= 1'b1;
         end
      end
   end

   assign SEG_SELECT_OUT = r_index;
   assign BIN_OUT        = r_digits[{r_index, 2'b00} +: 4];
   assign DOT_OUT        = r_dots[r_index];
   assign LOAD_ACK_OUT   = r_ack;
   assign FRAME_DONE_OUT = r_frame_done;

endmodule : seg7_scan_controller
`default_nettype wire

// File: tb/tb_seg7_scan_controller.sv
`default_nettype none
// ============================================================================
// tb_seg7_scan_controller : directed bench, PRESCALE=4 and PRESCALE=1 builds
// Rev 1.0
// ============================================================================
module tb_seg7_scan_controller;

   logic        clk = 1'b0;
   logic        rst, rst1;
   logic        req, req1;
   logic [15:0] digits, digits1;
   logic [3:0]  dots, dots1;
   logic        ack, fd, dot;
   logic [1:0]  sel;
   logic [3:0]  bin;
   logic        ack1, fd1, dot1;
   logic [1:0]  sel1;
   logic [3:0]  bin1;

   int checks   = 0;
   int failures = 0;
   int acks;
   bit got;

   always #5 clk = ~clk;

   seg7_scan_controller #(.PRESCALE(4), .CNT_W(17)) u_dut (
      .CLK(clk), .RESET(rst), .LOAD_REQ_IN(req), .DIGITS_IN(digits), .DOTS_IN(dots),
      .LOAD_ACK_OUT(ack), .FRAME_DONE_OUT(fd), .SEG_SELECT_OUT(sel),
      .BIN_OUT(bin), .DOT_OUT(dot)
   );

   seg7_scan_controller #(.PRESCALE(1), .CNT_W(17)) u_dut1 (
      .CLK(clk), .RESET(rst1), .LOAD_REQ_IN(req1), .DIGITS_IN(digits1), .DOTS_IN(dots1),
      .LOAD_ACK_OUT(ack1), .FRAME_DONE_OUT(fd1), .SEG_SELECT_OUT(sel1),
      .BIN_OUT(bin1), .DOT_OUT(dot1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; rst1 = 1'b1;
      req = 1'b0; req1 = 1'b0;
      digits = 16'h0; digits1 = 16'h0;
      dots = 4'h0; dots1 = 4'h0;
      step(3);
      check("reset_sel", {30'd0, sel}, 0);
      check("reset_bin", {28'd0, bin}, 0);
      check("reset_dot", {31'd0, dot}, 0);
      check("reset_ack", {31'd0, ack}, 0);
      check("reset_fd",  {31'd0, fd}, 0);
      check("reset_sel1", {30'd0, sel1}, 0);

      // Edge count k after release: slot = (k/4)%4, frame done after k%16==0.
      rst = 1'b0; rst1 = 1'b0;
      for (int k = 1; k <= 31; k++) begin
         step(1);
         check("scan_sel", {30'd0, sel}, (k / 4) % 4);
         check("scan_fd",  {31'd0, fd}, (k % 16 == 0) ? 1 : 0);
         if (k <= 20) check("scan_sel_p1", {30'd0, sel1}, k % 4);
      end

      // Now at k=31: boundary cycle (count 3, slot 3).
      req = 1'b1; digits = 16'h1234; dots = 4'b0101;
      step(1); // k=32
      check("load_ack", {31'd0, ack}, 1);
      check("load_fd",  {31'd0, fd}, 1);
      check("load_s0_bin", {28'd0, bin}, 4'h4);
      check("load_s0_dot", {31'd0, dot}, 1);
      req = 1'b0;
      step(1); // k=33
      check("load_ack_drop", {31'd0, ack}, 0);
      step(3); // k=36
      check("load_s1_bin", {28'd0, bin}, 4'h3);
      check("load_s1_dot", {31'd0, dot}, 0);
      step(4); // k=40
      check("load_s2_bin", {28'd0, bin}, 4'h2);
      check("load_s2_dot", {31'd0, dot}, 1);
      step(4); // k=44
      check("load_s3_bin", {28'd0, bin}, 4'h1);
      check("load_s3_dot", {31'd0, dot}, 0);

      // Mid-frame request raised in slot 1 (k=52).
      step(8); // k=52
      req = 1'b1; digits = 16'hABCD; dots = 4'b0000;
      step(1); // k=53
      check("mid_no_ack", {31'd0, ack}, 0);
      check("mid_s1_old", {28'd0, bin}, 4'h3);
      step(3); // k=56
      check("mid_s2_old", {28'd0, bin}, 4'h2);
      step(4); // k=60
      check("mid_s3_old", {28'd0, bin}, 4'h1);
      check("mid_s3_noack", {31'd0, ack}, 0);
      step(4); // k=64
      check("mid_ack", {31'd0, ack}, 1);
      check("mid_s0_new", {28'd0, bin}, 4'hD);
      check("mid_s0_dot", {31'd0, dot}, 0);
      req = 1'b0;
      step(1); // k=65
      check("mid_ack_drop", {31'd0, ack}, 0);

      // Held request k=66..105: boundaries captured at k=80 and k=96.
      req = 1'b1; digits = 16'h00F0; dots = 4'b0000;
      acks = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (ack) acks++;
      end
      req = 1'b0;
      check("held_ack_count", acks, 2);
      step(7); // k=112, slot 0
      for (int s = 0; s < 4; s++) begin
         check("held_sel", {30'd0, sel}, s);
         check("held_bin", {28'd0, bin}, (s == 1) ? 4'hF : 4'h0);
         step(4);
      end
      // k=128; slot 2 spans k=136..139.
      step(9); // k=137
      req = 1'b1; digits = 16'h5555; dots = 4'b1111;
      rst = 1'b1;
      step(1);
      check("rst_mid_sel", {30'd0, sel}, 0);
      check("rst_mid_bin", {28'd0, bin}, 0);
      check("rst_mid_dot", {31'd0, dot}, 0);
      check("rst_mid_ack", {31'd0, ack}, 0);
      check("rst_mid_fd",  {31'd0, fd}, 0);
      rst = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         step(1);
         check("rst_no_ack", {31'd0, ack}, 0);
         check("rst_buf_zero", {28'd0, bin}, 0);
      end
      step(1);
      check("rst_first_ack", {31'd0, ack}, 1);
      check("rst_new_bin", {28'd0, bin}, 4'h5);
      check("rst_new_dot", {31'd0, dot}, 1);
      req = 1'b0;

      // PRESCALE=1 handshake: requester drops REQ as soon as it sees ACK.
      req1 = 1'b1; digits1 = 16'h9876; dots1 = 4'b1000;
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
         step(1);
         if (ack1) got = 1'b1;
      end
      check("p1_ack_within4", {31'd0, got}, 1);
      check("p1_sel_after", {30'd0, sel1}, 0);
      check("p1_bin_s0", {28'd0, bin1}, 4'h6);
      check("p1_dot_s0", {31'd0, dot1}, 0);
      req1 = 1'b0;
      step(1);
      check("p1_sel_s1", {30'd0, sel1}, 1);
      check("p1_bin_s1", {28'd0, bin1}, 4'h7);
      step(2);
      check("p1_dot_s3", {31'd0, dot1}, 1);
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (ack1) acks++;
      end
      check("p1_single_capture", acks, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_seg7_scan_controller
`default_nettype wire
